// File: rtl/psec5_spi_pkg.sv
// Shared types and constants for the PSEC5 SPI host controller.
// Register map and instruction codes mirror the slave's configuration space.
package psec5_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ADDR,
        ST_WLOAD,
        ST_DATA,
        ST_TAIL
    } state_t;

    localparam int PRE_PULSES = 8;
    localparam int BYTE_BITS  = 8;

    localparam logic [7:0] REG_TCM        = 8'd1;
    localparam logic [7:0] REG_INST       = 8'd2;
    localparam logic [7:0] REG_MODE       = 8'd3;
    localparam logic [7:0] REG_RD_FIRST   = 8'd4;
    localparam logic [7:0] REG_RD_LAST    = 8'd59;
    localparam logic [7:0] REG_PLL_LOCKED = 8'd60;
    localparam logic [7:0] REG_DISC_POL   = 8'd61;
    localparam logic [7:0] REG_VCO        = 8'd62;
    localparam logic [7:0] REG_PLL_DIV    = 8'd63;
    localparam logic [7:0] REG_SLOW       = 8'd64;
    localparam logic [7:0] REG_TRIG_DLY   = 8'd65;

    localparam logic [7:0] INST_RST       = 8'd1;
    localparam logic [7:0] INST_READOUT   = 8'd2;
    localparam logic [7:0] INST_START     = 8'd3;

endpackage

// File: rtl/psec5_spi_bit_timer.sv
// Divides clk into bit slots of 2*HALF cycles (low phase first, then high phase).
// phase_high describes the cycle after the current edge so pin flops can be loaded directly.
module psec5_spi_bit_timer #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic phase_high,
    output logic slot_end,
    output logic sample
);

    localparam int SLOT = 2 * HALF;
    localparam int CW   = $clog2(SLOT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        slot_end = en && (cnt == CW'(SLOT - 1));
        sample   = slot_end;
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (en) begin
            cnt_next = slot_end ? '0 : cnt + CW'(1);
        end
        phase_high = en && (cnt_next >= CW'(HALF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/psec5_spi_master.sv
// Host-side SPI controller: turns one command into a full PSEC5 slave frame
// (preamble, address byte, N data bytes, optional instruction-firing tail pulses).
module psec5_spi_master
    import psec5_spi_pkg::*;
#(
    parameter int HALF  = 1,
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_addr,
    input  logic             cmd_write,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_tail,
    input  logic [7:0]       wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [7:0]       rdata,
    output logic             rdata_valid,
    output logic             done,
    output logic             sclk,
    output logic             iclk,
    output logic             serial_in,
    input  logic             serial_out
);

    state_t           state;
    state_t           end_state;
    logic [7:0]       addr_q;
    logic             write_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       tail_q;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic [3:0]       tail_cnt;
    logic [7:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic             timer_en;
    logic             phase_high;
    logic             slot_end;
    logic             sample;
    logic             last_bit;
    logic             last_byte;

    always_comb begin
        timer_en    = state inside {ST_PRE, ST_ADDR, ST_DATA, ST_TAIL};
        cmd_ready   = (state == ST_IDLE);
        wdata_ready = (state == ST_WLOAD) && wdata_valid;
        last_bit    = (bit_cnt == 3'(BYTE_BITS - 1));
        last_byte   = (byte_cnt == len_q - LEN_W'(1));
        end_state   = (tail_q == 4'd0) ? ST_IDLE : ST_TAIL;
    end

    // Held cleared outside active slots, so a WLOAD stall restarts the next slot cleanly.
    psec5_spi_bit_timer #(.HALF(HALF)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (timer_en),
        .clr        (!timer_en),
        .phase_high (phase_high),
        .slot_end   (slot_end),
        .sample     (sample)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            len_q       <= '0;
            tail_q      <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            tail_cnt    <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            done        <= 1'b0;
            sclk        <= 1'b0;
            iclk        <= 1'b0;
            serial_in   <= 1'b0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            // The preamble pulses iclk alone; every other slot pulses both clocks.
            sclk        <= phase_high && (state != ST_PRE);
            iclk        <= phase_high;
            if (sample && state == ST_DATA) begin
                rx_shift <= {rx_shift[6:0], serial_out};
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q    <= cmd_addr;
                        write_q   <= cmd_write;
                        len_q     <= cmd_len;
                        tail_q    <= cmd_tail;
                        bit_cnt   <= '0;
                        byte_cnt  <= '0;
                        tail_cnt  <= '0;
                        rx_shift  <= '0;
                        serial_in <= 1'b0;
                        state     <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (slot_end) begin
                        if (bit_cnt == 3'(PRE_PULSES - 1)) begin
                            bit_cnt   <= '0;
                            tx_shift  <= addr_q;
                            serial_in <= addr_q[7];
                            state     <= ST_ADDR;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (slot_end) begin
                        if (!last_bit) begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx_shift  <= {tx_shift[6:0], 1'b0};
                            serial_in <= tx_shift[6];
                        end else begin
                            bit_cnt   <= '0;
                            serial_in <= 1'b0;
                            tx_shift  <= '0;
                            if (len_q == '0) begin
                                state <= end_state;
                                done  <= (tail_q == 4'd0);
                            end else begin
                                state <= write_q ? ST_WLOAD : ST_DATA;
                            end
                        end
                    end
                end
                ST_WLOAD: begin
                    if (wdata_valid) begin
                        tx_shift  <= wdata;
                        serial_in <= wdata[7];
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (slot_end) begin
                        if (!last_bit) begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx_shift  <= {tx_shift[6:0], 1'b0};
                            serial_in <= tx_shift[6];
                        end else begin
                            bit_cnt   <= '0;
                            serial_in <= 1'b0;
                            tx_shift  <= '0;
                            if (!write_q) begin
                                rdata       <= {rx_shift[6:0], serial_out};
                                rdata_valid <= 1'b1;
                            end
                            if (last_byte) begin
                                state <= end_state;
                                done  <= (tail_q == 4'd0);
                            end else begin
                                byte_cnt <= byte_cnt + LEN_W'(1);
                                state    <= write_q ? ST_WLOAD : ST_DATA;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (slot_end) begin
                        if (tail_cnt == tail_q - 4'd1) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            tail_cnt <= tail_cnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/psec5_spi_master.md
# psec5_spi_master

Host-side SPI controller for the PSEC5 configuration/readout slave. Turns one command (address, direction, byte count, trailing-pulse count) into a complete slave frame on `sclk`/`iclk`/`serial_in` and captures `serial_out` for reads. A frame is a frame-reset preamble, an address byte and N auto-incrementing data bytes. It sits in the FPGA/test-harness logic driving the chip pins, so the slave is exercised exactly as in silicon bring-up.

## Interface
- `HALF`, 1: `sclk` half-period in `clk` cycles (≥1).
- `LEN_W`, 7: width of `cmd_len`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake; transfer when both high.
- `cmd_addr`  in  8  start register address (not range-checked).
- `cmd_write`  in  1  1 = write frame, 0 = read frame.
- `cmd_len`  in  LEN_W  data bytes; 0 = address-only frame.
- `cmd_tail`  in  4  extra `sclk`+`iclk` pulses after the last byte, used to fire instructions.
- `wdata` / `wdata_valid` / `wdata_ready`  in/in/out  8/1/1  write byte stream.
- `rdata` / `rdata_valid`  out  8/1  captured read byte; 1-cycle strobe, no backpressure.
- `done`  out  1  1-cycle pulse at frame end.
- `sclk`, `iclk`, `serial_in`  out  1  slave pins (`serial_in` is MOSI).
- `serial_out`  in  1  slave MISO.

## Operation
- Bit slot = 2·HALF cycles: low phase, then high phase. During the low phase `sclk` = `iclk` = 0 and `serial_in` holds the bit. During the high phase `sclk` = `iclk` = 1.
- Bytes go out MSB first. `serial_out` is sampled on the last `clk` edge of each high phase and shifted in MSB first.
- States: IDLE → PRE → ADDR → (WLOAD → DATA)* or DATA* → TAIL → IDLE.
- IDLE: `cmd_ready`=1. On accept, latch all command fields.
- PRE: 8 slots with `iclk` pulsing, `sclk` held 0 and `serial_in`=0. This resets the slave's frame state.
- ADDR: one byte carrying `cmd_addr`.
- Write: WLOAD drives `wdata_ready`=`wdata_valid`. It leaves only on a transfer, taking 1 cycle minimum. If `wdata_valid` is low, it stalls with `sclk`=`iclk`=0 for as long as needed. DATA then shifts the loaded byte.
- Read: DATA shifts 0x00 out. `rdata_valid` pulses on the cycle after the byte's 8th sample, with `rdata` = the assembled byte. `rdata` holds until the next strobe.
- Byte counter runs 0..`cmd_len`-1. If `cmd_len`=0, ADDR is followed directly by TAIL.
- TAIL: `cmd_tail` full slots (`sclk` and `iclk` both pulse) with `serial_in`=0. If `cmd_tail`=0, TAIL is skipped.
- `done` pulses in the first IDLE cycle after the frame.
- `rst` (any state): next edge returns to IDLE and clears the counters and shift registers. The slave frame is abandoned; the next command's PRE resynchronises the slave.
- `cmd_valid` while busy is ignored; the host holds it.

## Timing
- Reset values: `sclk`, `iclk`, `serial_in`, `wdata_ready`, `rdata_valid`, `done` = 0; `rdata` = 0x00; `cmd_ready` = 1 from the first post-reset cycle.
- All pin outputs are registered, with no combinational path from `serial_out`.
- Accept edge = cycle 0. PRE low phase starts in cycle 1.
- Read frame, no stalls: `done` is high in cycle 2·HALF·(16 + 8·len + tail) + 1.
- Write frame: add `len` (WLOAD cycles) plus any stall cycles.
- `rdata_valid` for byte k (0-based) is high in cycle 2·HALF·(16 + 8·(k+1)) + 1.
- Back-to-back commands: `cmd_ready` is high in the `done` cycle, so the next accept can occur there.

## Structure
- Package `psec5_spi_pkg` holds:
  - State enum.
  - `PRE_PULSES`=8, `BYTE_BITS`=8.
  - Register addresses: TCM=1, INST=2, MODE=3, RD_FIRST=4, RD_LAST=59, PLL_LOCKED=60, DISC_POL=61, VCO=62, PLL_DIV=63, SLOW=64, TRIG_DLY=65.
  - Instruction codes: RST=1, READOUT=2, START=3.
- Sub-module `psec5_spi_bit_timer`: HALF-cycle divider. Emits `phase_high`, `slot_end` and `sample` strobes, and is enabled/cleared by the FSM (it is held cleared during WLOAD stalls).

## Test plan
- Write addr 1, len 3, data 0x29/0x01/0x04, HALF=1 -> slave TCM=0x29, instruction=0x01, mode=0x04; `done` in cycle 2·(16+24)+3+1 = 84.
- Read addr 4, len 57 -> 57 `rdata_valid` strobes at the stated cycles; byte 56 = `pll_locked` = 0x01; slave `load_cnt_ser`/`select_reg` step per register.
- Write addr 61, len 5, data 0xA9/0x36/0x07/0x00/0x01, HALF=3 -> slave disc_polarity/vco/pll_div/slow/trig_delay match; each `sclk` level lasts 3 cycles.
- Write addr 2, data 0x03, tail 2 -> slave `inst_start`=1 and `clk_enable`=1 after tail pulse 1; `inst_start`=0 and `clk_enable`=1 after pulse 2.
- Write len 2 with `wdata_valid` low for 10 cycles before byte 2 -> `sclk`=`iclk`=0 throughout the stall, data still correct, `done` delayed exactly 10 cycles.
- Assert `rst` mid-ADDR -> next edge all pins 0 and `cmd_ready`=1, no `done`; a following read of addr 1 returns 0x29.
